// File: rtl/cpu_pkg.sv
// Shared definitions for the processor front end: fetch FSM states,
// instruction width, NOP encoding and the default reset fetch address.
package cpu_pkg;

    localparam int unsigned INSTR_WIDTH      = 16;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Fetch address register with load (redirect) > increment > hold priority.
// pc_plus1 is the successor of the presented instruction's pc, modulo 2^ADDR_WIDTH.
module pc_counter #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  incr,
    input  logic [ADDR_WIDTH-1:0] cur_pc,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [ADDR_WIDTH-1:0] pc_plus1
);

    assign pc_plus1 = cur_pc + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (load) begin
            fetch_pc <= load_value;
        end else if (incr) begin
            fetch_pc <= pc_plus1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC ownership, BRAM read sequencing, instruction register
// with valid/ready handoff and redirect flush. Optional prefetch: IFU_PREFETCH_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rd_en,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [ADDR_WIDTH-1:0]  pc_plus1,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_target
);

    fetch_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic load_pc, incr_pc, capture, accept;

    assign instr_valid = (state == S_HOLD);
    assign accept      = instr_valid & instr_ready;

    pc_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (load_pc),
        .load_value (redirect_target),
        .incr       (incr_pc),
        .cur_pc     (pc),
        .fetch_pc   (fetch_pc),
        .pc_plus1   (pc_plus1)
    );

`ifdef IFU_PREFETCH_EN
    logic [INSTR_WIDTH-1:0] pf_data, pf_word;
    logic pf_valid, pf_inflight, pf_avail, pf_issue, take_pf;

    // A prefetch slot is either registered (pf_valid) or on the RAM bus now (pf_inflight).
    assign pf_avail = pf_valid | pf_inflight;
    assign pf_word  = pf_valid ? pf_data : mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_pc    = 1'b0;
        incr_pc    = 1'b0;
        capture    = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = fetch_pc;
`ifdef IFU_PREFETCH_EN
        pf_issue   = 1'b0;
        take_pf    = 1'b0;
`endif
        case (state)
            S_REQ: begin
                mem_rd_en  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                capture    = 1'b1;
                state_next = S_HOLD;
`ifdef IFU_PREFETCH_EN
                // Reading the successor here lets the first HOLD cycle already hand over.
                mem_rd_en  = 1'b1;
                mem_addr   = fetch_pc + ADDR_WIDTH'(1);
                pf_issue   = 1'b1;
`endif
            end
            S_HOLD: begin
`ifdef IFU_PREFETCH_EN
                if (accept && pf_avail) begin
                    take_pf   = 1'b1;
                    pf_issue  = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = pc_plus1 + ADDR_WIDTH'(1);
                end else if (accept) begin
                    // The read issued now becomes the WAIT fetch; no second read.
                    incr_pc    = 1'b1;
                    mem_rd_en  = 1'b1;
                    mem_addr   = pc_plus1;
                    state_next = S_WAIT;
                end else if (!pf_avail) begin
                    pf_issue  = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = pc_plus1;
                end
`else
                if (accept) begin
                    incr_pc    = 1'b1;
                    state_next = S_REQ;
                end
`endif
            end
            default: state_next = S_REQ;
        endcase

        if (redirect) begin
            load_pc    = 1'b1;
            incr_pc    = 1'b0;
            capture    = 1'b0;
            state_next = S_REQ;
`ifdef IFU_PREFETCH_EN
            pf_issue   = 1'b0;
            take_pf    = 1'b0;
`endif
        end

        if (reset) begin
            mem_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc    <= RESET_PC;
        end else if (capture) begin
            instr <= mem_rdata;
            pc    <= fetch_pc;
`ifdef IFU_PREFETCH_EN
        end else if (take_pf) begin
            instr <= pf_word;
            pc    <= pc_plus1;
`endif
        end
    end

`ifdef IFU_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            pf_valid    <= 1'b0;
            pf_inflight <= 1'b0;
            pf_data     <= NOP_INSTR;
        end else begin
            pf_inflight <= pf_issue;
            if (take_pf) begin
                pf_valid <= 1'b0;
            end else if (pf_inflight) begin
                pf_valid <= 1'b1;
                pf_data  <= mem_rdata;
            end
        end
    end
`endif

endmodule
